// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM arbiter slice.
// Holds the default BRAM geometry, the requester id type carried through the
// read-tag pipe, and the ownership encoding used by the arbiter FSM.
package bram_pkg;

  localparam int BRAM_ADDR_W = 20;
  localparam int BRAM_DATA_W = 32;

  // 0 = riscv core, 1 = UART program loader
  typedef logic port_id_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Read-tag delay line for the BRAM arbiter.
// Carries {valid, port_id} of each granted read for RD_LAT cycles so the
// returning BRAM data can be steered to the requester that issued it.
// Ports:
//   clk, rst   - clock and synchronous active-high clear of the valid bits
//   push_vld_i - a read was granted this cycle
//   push_id_i  - which port owns that read
//   pop_vld_o  - tag at the BRAM output stage is valid
//   pop_id_o   - port id of that tag
module bram_rd_tag_pipe
  import bram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_vld_i,
  input  port_id_t push_id_i,
  output logic     pop_vld_o,
  output port_id_t pop_id_o
);

  logic     vld_p [RD_LAT];
  port_id_t id_p  [RD_LAT];

  // Stage 0 .. RD_LAT-1: valid bits are cleared on reset so in-flight reads
  // are dropped; the id travels alongside and needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= push_vld_i;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_p[0] <= push_id_i;
    for (int i = 1; i < RD_LAT; i++) id_p[i] <= id_p[i-1];
  end

  assign pop_vld_o = vld_p[RD_LAT-1];
  assign pop_id_o  = id_p[RD_LAT-1];

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for the single-port BRAM shared by the riscv core
// (port 0) and the UART program loader (port 1).
// Round-robin between ports when nobody owns the BRAM; a beat with lockN=1
// keeps ownership for port N until it issues an unlocked beat. The BRAM port
// is driven combinationally from the winner, and read data comes back after
// RD_LAT cycles with a per-port valid.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   reqN/weN/lockN      - request, write/read select, keep-ownership flag
//   adrN/wdataN         - byte address (word bits [ADDR_W+1:2] used), write data
//   gntN                - beat accepted this cycle (combinational)
//   rvalidN, rdata      - read return for port N, shared data bus
//   bram_we/addr/din    - BRAM write enable, word address, write data
//   bram_dout           - BRAM read data
// ADDR_W must be at most 29 so the word address fits in a 32-bit byte address.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [31:0]       adr0,
  input  logic [31:0]       adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  owner_t   owner_q, owner_d;
  port_id_t prio_q,  prio_d;

  logic     tag_vld;
  port_id_t tag_id;

  // Byte-lane and out-of-range address bits are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{adr0[31:ADDR_W+2], adr0[1:0], adr1[31:ADDR_W+2], adr1[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      prio_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  // Grant selection: an owner excludes the other port even while idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (owner_q)
        OWN_P0: gnt0 = req0;
        OWN_P1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = (prio_q == 1'b0);
            gnt1 = (prio_q == 1'b1);
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // Ownership/priority update; an unlocked beat hands preference to the peer.
  always_comb begin
    owner_d = owner_q;
    prio_d  = prio_q;
    if (gnt0) begin
      owner_d = lock0 ? OWN_P0 : OWN_NONE;
      if (!lock0) prio_d = 1'b1;
    end else if (gnt1) begin
      owner_d = lock1 ? OWN_P1 : OWN_NONE;
      if (!lock1) prio_d = 1'b0;
    end
  end

  always_comb begin
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (gnt0) begin
      bram_we   = we0;
      bram_addr = adr0[ADDR_W+1:2];
      bram_din  = wdata0;
    end else if (gnt1) begin
      bram_we   = we1;
      bram_addr = adr1[ADDR_W+1:2];
      bram_din  = wdata1;
    end
  end

  bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i ((gnt0 && !we0) || (gnt1 && !we1)),
    .push_id_i  (gnt1),
    .pop_vld_o  (tag_vld),
    .pop_id_o   (tag_id)
  );

  // Masking with rst drops the tag already at the output when reset lands
  // one cycle after a read grant; the pipe itself clears at the next edge.
  assign rvalid0 = tag_vld && (tag_id == 1'b0) && !rst;
  assign rvalid1 = tag_vld && (tag_id == 1'b1) && !rst;
  assign rdata   = bram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1, lock0, lock1;
  logic [31:0]       adr0, adr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .adr0(adr0), .adr1(adr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Small single-port BRAM model with one cycle of read latency.
  logic [DATA_W-1:0] mem [256];
  always_ff @(posedge clk) begin
    if (bram_we) mem[bram_addr[7:0]] <= bram_din;
    bram_dout <= mem[bram_addr[7:0]];
  end

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rd_t;
  rd_t exp_q[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic l,
                      input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; lock0 = l; adr0 = a; wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l,
                      input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = w; lock1 = l; adr1 = a; wdata1 = d;
  endtask

  // One cycle: sample at negedge, check read returns against the scoreboard,
  // check grant and BRAM port, optionally queue an expected read, advance.
  task automatic step(input logic g0, input logic g1, input logic we,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic push, input logic pport, input logic [31:0] pdata);
    bit ev0, ev1;
    @(negedge clk);
    ev0 = (exp_q.size() > 0) && (exp_q[0].port == 1'b0);
    ev1 = (exp_q.size() > 0) && (exp_q[0].port == 1'b1);
    chk("rvalid0", rvalid0, ev0);
    chk("rvalid1", rvalid1, ev1);
    if (exp_q.size() > 0) begin
      chk("rdata", rdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("bram_we", bram_we, we);
    chk("bram_addr", bram_addr, addr);
    chk("bram_din", bram_din, din);
    if (push) exp_q.push_back('{port: pport, data: pdata});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv0(1'b1, 1'b1, 1'b0, 32'h10, 32'h1111_2222);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    // Reset: requests are ignored while rst is high
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Preload word 4 through port 0
    drv0(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
    step(1, 0, 1, 4, 32'hDEAD_BEEF, 0, 0, 0);
    // Lone read of word 4
    drv0(1, 0, 0, 32'h0000_0010, 32'h0);
    step(1, 0, 0, 4, 0, 1, 0, 32'hDEAD_BEEF);
    // Idle: BRAM port parked at zero, read returns
    drv0(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Address bits outside [21:2] ignored
    drv0(1, 1, 0, 32'hFFC0_0007, 32'h1111_1111);
    step(1, 0, 1, 1, 32'h1111_1111, 0, 0, 0);
    // Write then read of 0x40 in the next cycle
    drv0(1, 1, 0, 32'h0000_0040, 32'h1234_5678);
    step(1, 0, 1, 16, 32'h1234_5678, 0, 0, 0);
    drv0(1, 0, 0, 32'h0000_0040, 32'h0);
    step(1, 0, 0, 16, 0, 1, 0, 32'h1234_5678);
    // Locked read, then reset lands the next cycle: no return, lock dropped
    drv0(1, 0, 1, 32'h0000_0010, 32'h0);
    step(1, 0, 0, 4, 0, 0, 0, 0);
    rst = 1'b1;
    drv0(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Contention from reset: prio=0 so port 0 first, then alternate
    drv0(1, 0, 0, 32'h0000_0010, 32'h0);
    drv1(1, 0, 0, 32'h0000_0040, 32'h0);
    step(1, 0, 0, 4,  0, 1, 0, 32'hDEAD_BEEF);
    step(0, 1, 0, 16, 0, 1, 1, 32'h1234_5678);
    step(1, 0, 0, 4,  0, 1, 0, 32'hDEAD_BEEF);
    step(0, 1, 0, 16, 0, 1, 1, 32'h1234_5678);

    // Locked burst: port 1 writes words 0..3, port 0 waits then wins
    drv0(0, 0, 0, 32'h0, 32'h0);
    drv1(1, 1, 1, 32'h0000_0000, 32'hCAFE_00A0);
    step(0, 1, 1, 0, 32'hCAFE_00A0, 0, 0, 0);
    drv0(1, 0, 0, 32'h0000_0004, 32'h0);
    drv1(1, 1, 1, 32'h0000_0004, 32'hCAFE_00A1);
    step(0, 1, 1, 1, 32'hCAFE_00A1, 0, 0, 0);
    drv1(1, 1, 1, 32'h0000_0008, 32'hCAFE_00A2);
    step(0, 1, 1, 2, 32'hCAFE_00A2, 0, 0, 0);
    drv1(1, 1, 0, 32'h0000_000C, 32'hCAFE_00A3);
    step(0, 1, 1, 3, 32'hCAFE_00A3, 0, 0, 0);
    drv1(0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 1, 0, 1, 0, 32'hCAFE_00A1);

    // Lock held with no request: port 0 starves until port 1 unlocks
    drv0(0, 0, 0, 32'h0, 32'h0);
    drv1(1, 0, 1, 32'h0000_0000, 32'h0);
    step(0, 1, 0, 0, 0, 1, 1, 32'hCAFE_00A0);
    drv0(1, 0, 0, 32'h0000_0008, 32'h0);
    drv1(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drv1(1, 0, 0, 32'h0000_000C, 32'h0);
    step(0, 1, 0, 3, 0, 1, 1, 32'hCAFE_00A3);
    drv1(0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 2, 0, 1, 0, 32'hCAFE_00A2);
    drv0(0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter for the single-port 32-bit block RAM shared by the `riscv` core and the UART program loader. It picks one request per cycle by round-robin, supports locked bursts for the loader, drives the BRAM port combinationally, and routes read data back to the winner with a per-port valid after the fixed BRAM read latency. It sits in `top` between the requesters and `blk_mem_gen_0`.

## Interface
- `ADDR_W`, 20: BRAM word-address width; byte-address bits [ADDR_W+1:2] are used.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: BRAM read latency in cycles (legal values 1..4).

- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request (0 = core, 1 = loader).
- `we0` / `we1`  in  1  write (1) or read (0).
- `lock0` / `lock1`  in  1  keep ownership after this beat.
- `adr0` / `adr1`  in  32  byte address; bits [1:0] and above ADDR_W+1 are ignored.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  beat accepted this cycle (combinational).
- `rvalid0` / `rvalid1`  out  1  `rdata` holds this port's read result.
- `rdata`  out  DATA_W  read data, shared by both ports.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  ADDR_W  BRAM word address.
- `bram_din`  out  DATA_W  BRAM write data.
- `bram_dout`  in  DATA_W  BRAM read data.

## Operation
- Beat transfer: a beat transfers in any cycle where `reqN && gntN`.
- Requester stability: after raising `reqN`, the requester holds `weN`, `adrN`, `wdataN` and `lockN` stable until that beat transfers.
- Grant rule:
  - At most one grant per cycle.
  - A grant is never given without a request.
  - The grant is given in the same cycle as the request when the port wins.
- Arbitration state:
  - `owner`: {NONE, P0, P1}.
  - `prio`: 1-bit pointer to the preferred port.
- Arbitration when `owner` = NONE:
  - If both ports request, the port named by `prio` wins.
  - If one port requests, that port wins.
- Arbitration when `owner` = PN: only port N can be granted; the other port waits even if PN is idle that cycle.
- Update on a granted beat from port N:
  - `lockN` = 1: `owner` becomes PN.
  - `lockN` = 0: `owner` becomes NONE and `prio` points to the other port.
- BRAM port mux:
  - `bram_we` = `we` of the winner, gated by the grant.
  - `bram_addr` = winner `adr[ADDR_W+1:2]`.
  - `bram_din` = winner `wdata`.
  - With no grant: `bram_we`=0, `bram_addr`=0, `bram_din`=0.
- Read return:
  - Each granted read pushes the port id into an RD_LAT-deep tag pipe.
  - `rvalidN` asserts exactly RD_LAT cycles after the grant, for one cycle.
  - `rdata` = `bram_dout`, unregistered.
- Writes produce no `rvalid`.
- Read-during-write ordering is whatever the BRAM does. A write followed by a read of the same address in the next cycle returns the new data.

## Timing
- Reset values:
  - `owner`=NONE, `prio`=0, tag pipe empty.
  - `gnt0`/`gnt1`=0 and `bram_we`=0 while `rst` is high.
  - `rvalid0`/`rvalid1`=0.
- Reset mid-operation:
  - In-flight read tags are discarded; no `rvalid` follows for reads granted before reset.
  - An active lock is released.
- Read latency: grant in cycle t gives `rvalid` in cycle t+RD_LAT.
- Throughput: one beat per cycle, including back-to-back reads from alternating ports.
- Pipelined returns: return order equals grant order, and the pipe never stalls.
- Lock held with no request: a locked owner that drops `req` keeps the BRAM; the other port starves until the owner issues an unlocked beat.

## Structure
- Shared package `bram_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults;
  - `port_id_t` (1 bit);
  - owner enum `owner_t` {OWN_NONE, OWN_P0, OWN_P1}.
- One sub-module, `bram_rd_tag_pipe`: an RD_LAT-stage shift register of {valid, port_id} with synchronous clear on `rst`.

## Test plan
- Lone read:
  - Stimulus: `req0`=1, `we0`=0, `adr0`=0x0000_0010, BRAM word 4 = 0xDEADBEEF.
  - Required: `gnt0` in cycle t; `bram_addr`=4 in cycle t; `rvalid0`=1 and `rdata`=0xDEADBEEF in cycle t+1.
- Contention and round-robin:
  - Stimulus: both ports request reads continuously from reset.
  - Required: grants alternate 0,1,0,1; each `rvalid` lands on the correct port one cycle after its grant.
- Locked burst:
  - Stimulus: port 1 writes words 0..3 with `lock1`=1 on beats 0..2 and 0 on beat 3; port 0 requests throughout.
  - Required: four consecutive `gnt1`; `gnt0` in the cycle after the last write.
- Write then read:
  - Stimulus: port 0 writes 0x12345678 to `adr` 0x40, then reads 0x40 in the next cycle.
  - Required: `rvalid0` carries `rdata`=0x12345678.
- Reset mid-read:
  - Stimulus: assert `rst` in the cycle after a read grant.
  - Required: no `rvalid`; after reset, `prio`=0, so with both ports requesting port 0 wins first.
- Address bits ignored:
  - Stimulus: `adr0`=0xFFC0_0007.
  - Required: `bram_addr`=1.
